// File: rtl/fifo_ser_pkg.sv
// Shared types and constants for the FIFO byte serializer.
// The default word/byte widths match the 32-bit synchronous FIFO feeding it.
package fifo_ser_pkg;

  localparam int FIFO_DATA_W    = 32;
  localparam int FIFO_BYTE_W    = 8;
  localparam int BYTES_PER_WORD = FIFO_DATA_W / FIFO_BYTE_W;
  localparam int BYTE_IDX_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  // Serializer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    SEND = 2'd3
  } ser_state_e;

  // Width of a byte index for a word holding n bytes (never zero).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_byte_serializer.sv
// Pops words from the upstream FIFO and emits them byte by byte over a
// valid/ready handshake. Counts fully emitted words for status readback.
// All outputs come straight from flops, so no input reaches an output
// combinationally.
module fifo_byte_serializer
  import fifo_ser_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int BYTE_W    = FIFO_BYTE_W,
  parameter int MSB_FIRST = 0,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  word_count
);

  localparam int BPW   = DATA_W / BYTE_W;
  localparam int IDX_W = idx_width(BPW);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

  ser_state_e        state_r;
  ser_state_e        next_state_s;
  logic [DATA_W-1:0] shift_r;
  logic [DATA_W-1:0] shift_nxt_s;
  logic [IDX_W-1:0]  idx_r;
  logic [IDX_W-1:0]  idx_nxt_s;
  logic [BYTE_W-1:0] byte_r;
  logic [BYTE_W-1:0] byte_sel_s;
  logic              rd_en_r;
  logic              valid_r;
  logic              busy_r;
  logic [CNT_W-1:0]  count_r;
  logic              start_ok_s;
  logic              handshake_s;
  logic              last_byte_s;

  // Qualifiers: may a new word start, and is a byte being accepted.
  always_comb begin
    start_ok_s  = enable & ~fifo_empty;
    handshake_s = (state_r == SEND) & byte_ready;
    last_byte_s = handshake_s & (idx_r == LAST_IDX);
  end

  // Next-state decode; a word in flight always runs to completion.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          next_state_s = REQ;
        end else begin
          next_state_s = IDLE;
        end
      end
      REQ:  next_state_s = WAIT;
      WAIT: next_state_s = SEND;
      SEND: begin
        if (last_byte_s) begin
          if (start_ok_s) begin
            next_state_s = REQ;
          end else begin
            next_state_s = IDLE;
          end
        end else begin
          next_state_s = SEND;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Next shift-register contents and byte index.
  always_comb begin
    shift_nxt_s = shift_r;
    idx_nxt_s   = idx_r;
    case (state_r)
      WAIT: begin
        shift_nxt_s = fifo_dout;
        idx_nxt_s   = {IDX_W{1'b0}};
      end
      SEND: begin
        if (last_byte_s) begin
          idx_nxt_s = {IDX_W{1'b0}};
        end else if (handshake_s) begin
          idx_nxt_s = idx_r + IDX_W'(1);
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      default: begin
        shift_nxt_s = shift_r;
        idx_nxt_s   = idx_r;
      end
    endcase
  end

  // Lane select for the next byte; MSB_FIRST reverses the lane order.
  always_comb begin
    byte_sel_s = {BYTE_W{1'b0}};
    for (int i = 0; i < BPW; i++) begin
      if (idx_nxt_s == IDX_W'(i)) begin
        byte_sel_s = shift_nxt_s[((MSB_FIRST != 0) ? (BPW - 1 - i) : i) * BYTE_W +: BYTE_W];
      end else begin
        byte_sel_s = byte_sel_s;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Word datapath: shift register, byte index and the registered output byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= {DATA_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      byte_r  <= {BYTE_W{1'b0}};
    end else begin
      shift_r <= shift_nxt_s;
      idx_r   <= idx_nxt_s;
      byte_r  <= byte_sel_s;
    end
  end

  // Control outputs registered from the next state so they track state_r exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_r <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      rd_en_r <= (next_state_s == REQ);
      valid_r <= (next_state_s == SEND);
      busy_r  <= (next_state_s != IDLE);
    end
  end

  // Drained-word counter, bumped on the final byte handshake; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (last_byte_s) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign fifo_rd_en = rd_en_r;
  assign byte_out   = byte_r;
  assign byte_valid = valid_r;
  assign busy       = busy_r;
  assign word_count = count_r;

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Bench for fifo_byte_serializer: two instances (LSB-first and MSB-first)
// share one stimulus. Each has its own behavioural FIFO; every popped word
// is expanded into the byte sequence it must produce, and a per-cycle
// compare process checks handshaked bytes, hold-while-stalled and the word
// counter. Directed sections pin the model with literal expectations.
module tb_fifo_byte_serializer;

  logic clk        = 1'b0;
  logic rst_n      = 1'b1;
  logic enable     = 1'b0;
  logic byte_ready = 1'b0;
  logic push_en    = 1'b0;
  logic [31:0] push_data = 32'h0;

  logic [1:0][31:0] fifo_dout_a  = '0;
  logic [1:0]       fifo_empty_a = 2'b11;
  logic [1:0]       rd_en_a;
  logic [1:0][7:0]  byte_out_a;
  logic [1:0]       valid_a;
  logic [1:0]       busy_a;
  logic [1:0][15:0] wcnt_a;

  int errors = 0;
  int checks = 0;

  // behavioural FIFOs and expected byte streams
  logic [31:0] fmem    [2][1024];
  int          wr_p    [2] = '{0, 0};
  int          rd_p    [2] = '{0, 0};
  int          pops    [2] = '{0, 0};
  logic [7:0]  exp_mem [2][4096];
  int          exp_wr  [2] = '{0, 0};
  int          exp_rd  [2] = '{0, 0};
  logic [31:0] fw;
  int          flane;

  // observation log
  int          cyc = 0;
  int          hs      [2] = '{0, 0};
  int          log_n   [2] = '{0, 0};
  logic [7:0]  log_b   [2][4096];
  int          log_c   [2][4096];
  int          rden_c  [2] = '{0, 0};
  logic        prev_hold [2] = '{1'b0, 1'b0};
  logic [7:0]  prev_byte [2];
  int          ck_wc;

  logic [7:0] t2_exp [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 8'h33, 8'h22, 8'h11};
  logic [7:0] t4_exp [8] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'hA1, 8'hB2, 8'hC3, 8'hD4};

  fifo_byte_serializer #(.DATA_W(32), .BYTE_W(8), .MSB_FIRST(0), .CNT_W(16)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .fifo_dout(fifo_dout_a[0]), .fifo_empty(fifo_empty_a[0]), .fifo_rd_en(rd_en_a[0]),
    .byte_out(byte_out_a[0]), .byte_valid(valid_a[0]), .byte_ready(byte_ready),
    .busy(busy_a[0]), .word_count(wcnt_a[0])
  );

  fifo_byte_serializer #(.DATA_W(32), .BYTE_W(8), .MSB_FIRST(1), .CNT_W(16)) dut_msb (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .fifo_dout(fifo_dout_a[1]), .fifo_empty(fifo_empty_a[1]), .fifo_rd_en(rd_en_a[1]),
    .byte_out(byte_out_a[1]), .byte_valid(valid_a[1]), .byte_ready(byte_ready),
    .busy(busy_a[1]), .word_count(wcnt_a[1])
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // FIFO model: pop on rd_en (data next cycle), push on push_en, flag updates at the edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rd_en_a[i]) begin
        pops[i]++;
        check(rd_p[i] != wr_p[i], $sformatf("pop_not_empty_i%0d", i), wr_p[i] - rd_p[i], 1);
        if (rd_p[i] == wr_p[i]) begin
          fifo_dout_a[i] <= 32'hDEADBEEF;
        end else begin
          fw = fmem[i][rd_p[i]];
          rd_p[i]++;
          fifo_dout_a[i] <= fw;
          for (int b = 0; b < 4; b++) begin
            flane = (i == 1) ? (3 - b) : b;
            exp_mem[i][exp_wr[i]] = fw[flane*8 +: 8];
            exp_wr[i]++;
          end
        end
      end
      if (push_en) begin
        fmem[i][wr_p[i]] = push_data;
        wr_p[i]++;
      end
      fifo_empty_a[i] <= (wr_p[i] == rd_p[i]);
    end
  end

  // Compare process on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        exp_rd[i]    = exp_wr[i];
        hs[i]        = 0;
        prev_hold[i] = 1'b0;
        check({valid_a[i], rd_en_a[i], busy_a[i]} == 3'b000 && wcnt_a[i] == 16'h0000,
              $sformatf("reset_state_i%0d", i), {valid_a[i], rd_en_a[i], busy_a[i], wcnt_a[i]}, 0);
      end else begin
        ck_wc = (hs[i] / 4) % 65536;
        check(wcnt_a[i] == 16'(ck_wc), $sformatf("word_count_i%0d", i), wcnt_a[i], ck_wc);
        if (prev_hold[i]) begin
          check(valid_a[i] == 1'b1 && byte_out_a[i] == prev_byte[i],
                $sformatf("hold_stable_i%0d", i), {valid_a[i], byte_out_a[i]}, {1'b1, prev_byte[i]});
        end
        if (rd_en_a[i]) rden_c[i] = cyc;
        if (valid_a[i]) begin
          check(busy_a[i] == 1'b1, $sformatf("busy_when_valid_i%0d", i), busy_a[i], 1);
          if (byte_ready) begin
            check(exp_rd[i] != exp_wr[i], $sformatf("byte_expected_i%0d", i), byte_out_a[i], 0);
            if (exp_rd[i] != exp_wr[i]) begin
              check(byte_out_a[i] == exp_mem[i][exp_rd[i]], $sformatf("byte_value_i%0d", i),
                    byte_out_a[i], exp_mem[i][exp_rd[i]]);
              exp_rd[i]++;
            end
            log_b[i][log_n[i]] = byte_out_a[i];
            log_c[i][log_n[i]] = cyc;
            log_n[i]++;
            hs[i]++;
          end
        end
        prev_hold[i] = valid_a[i] & ~byte_ready;
        prev_byte[i] = byte_out_a[i];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    push_en   = 1'b1;
    push_data = w;
    step();
    push_en   = 1'b0;
  endtask

  task automatic wait_quiet(input int max_cyc, input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < max_cyc) begin
      step();
      n++;
      if (busy_a == 2'b00 && rd_en_a == 2'b00) quiet++;
      else quiet = 0;
    end
    check(quiet >= 4, {tag, "_timeout"}, n, max_cyc);
  endtask

  task automatic check_bytes(input int inst, input int base, input logic [31:0] word, input string tag);
    int lane;
    for (int k = 0; k < 4; k++) begin
      lane = (inst == 1) ? (3 - k) : k;
      check(log_b[inst][base+k] == word[lane*8 +: 8], $sformatf("%s_i%0d_b%0d", tag, inst, k),
            log_b[inst][base+k], word[lane*8 +: 8]);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int lb [2];
    int pb [2];
    int n;
    logic [7:0] eb;

    // reset, then idle with an empty FIFO
    #1 rst_n = 1'b0;
    enable     = 1'b1;
    byte_ready = 1'b1;
    #102 rst_n = 1'b1;
    repeat (8) step();
    for (int i = 0; i < 2; i++) begin
      check({rd_en_a[i], valid_a[i], busy_a[i]} == 3'b000, $sformatf("t1_idle_i%0d", i),
            {rd_en_a[i], valid_a[i], busy_a[i]}, 0);
      check(wcnt_a[i] == 16'h0000, $sformatf("t1_count_i%0d", i), wcnt_a[i], 0);
      check(pops[i] == 0, $sformatf("t1_pops_i%0d", i), pops[i], 0);
    end

    // single word
    for (int i = 0; i < 2; i++) begin lb[i] = log_n[i]; pb[i] = pops[i]; end
    push(32'h44332211);
    wait_quiet(40, "t2");
    for (int i = 0; i < 2; i++) begin
      check(log_n[i] - lb[i] == 4, $sformatf("t2_nbytes_i%0d", i), log_n[i] - lb[i], 4);
      check(pops[i] - pb[i] == 1, $sformatf("t2_pops_i%0d", i), pops[i] - pb[i], 1);
      check(wcnt_a[i] == 16'd1, $sformatf("t2_count_i%0d", i), wcnt_a[i], 1);
      check(log_c[i][lb[i]] - rden_c[i] == 2, $sformatf("t2_latency_i%0d", i),
            log_c[i][lb[i]] - rden_c[i], 2);
      for (int k = 0; k < 4; k++) begin
        check(log_b[i][lb[i]+k] == t2_exp[i*4+k], $sformatf("t2_byte_i%0d_b%0d", i, k),
              log_b[i][lb[i]+k], t2_exp[i*4+k]);
      end
      for (int k = 0; k < 3; k++) begin
        check(log_c[i][lb[i]+k+1] - log_c[i][lb[i]+k] == 1, $sformatf("t2_consec_i%0d_b%0d", i, k),
              log_c[i][lb[i]+k+1] - log_c[i][lb[i]+k], 1);
      end
    end

    // burst of six words with ready toggling every cycle
    pulse_reset();
    for (int i = 0; i < 2; i++) begin lb[i] = log_n[i]; pb[i] = pops[i]; end
    for (int k = 0; k < 6; k++) begin
      push_en    = 1'b1;
      push_data  = 32'(k);
      byte_ready = ~byte_ready;
      step();
    end
    push_en = 1'b0;
    n = 0;
    while (n < 300 && !(wcnt_a[0] == 16'd6 && wcnt_a[1] == 16'd6 && busy_a == 2'b00)) begin
      byte_ready = ~byte_ready;
      step();
      n++;
    end
    check(n < 300, "t3_timeout", n, 300);
    byte_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check(log_n[i] - lb[i] == 24, $sformatf("t3_nbytes_i%0d", i), log_n[i] - lb[i], 24);
      check(pops[i] - pb[i] == 6, $sformatf("t3_pops_i%0d", i), pops[i] - pb[i], 6);
      check(wcnt_a[i] == 16'd6, $sformatf("t3_count_i%0d", i), wcnt_a[i], 6);
      for (int k = 0; k < 24; k++) begin
        eb = ((k % 4) == ((i == 1) ? 3 : 0)) ? 8'(k / 4) : 8'h00;
        check(log_b[i][lb[i]+k] == eb, $sformatf("t3_byte_i%0d_k%0d", i, k), log_b[i][lb[i]+k], eb);
      end
    end

    // byte order literal plus back-to-back throughput
    for (int i = 0; i < 2; i++) begin lb[i] = log_n[i]; pb[i] = pops[i]; end
    push(32'hA1B2C3D4);
    push(32'h55667788);
    wait_quiet(60, "t4");
    for (int i = 0; i < 2; i++) begin
      check(log_n[i] - lb[i] == 8, $sformatf("t4_nbytes_i%0d", i), log_n[i] - lb[i], 8);
      for (int k = 0; k < 4; k++) begin
        check(log_b[i][lb[i]+k] == t4_exp[i*4+k], $sformatf("t4_byte_i%0d_b%0d", i, k),
              log_b[i][lb[i]+k], t4_exp[i*4+k]);
      end
      check_bytes(i, lb[i] + 4, 32'h55667788, "t4_w1");
      check(log_c[i][lb[i]+4] - log_c[i][lb[i]] == 6, $sformatf("t4_word_period_i%0d", i),
            log_c[i][lb[i]+4] - log_c[i][lb[i]], 6);
      check(wcnt_a[i] == 16'd8, $sformatf("t4_count_i%0d", i), wcnt_a[i], 8);
    end

    // enable dropped after the second byte, then reset mid-word
    pulse_reset();
    for (int i = 0; i < 2; i++) begin lb[i] = log_n[i]; pb[i] = pops[i]; end
    push(32'h0000AA55);
    push(32'h12345678);
    push(32'h9ABCDEF0);
    n = 0;
    while (n < 40 && log_n[0] - lb[0] < 2) begin step(); n++; end
    check(n < 40, "t5_wait_two_bytes", n, 40);
    enable = 1'b0;
    wait_quiet(40, "t5a");
    for (int i = 0; i < 2; i++) begin
      check(log_n[i] - lb[i] == 4, $sformatf("t5_nbytes_i%0d", i), log_n[i] - lb[i], 4);
      check_bytes(i, lb[i], 32'h0000AA55, "t5_w0");
      check(pops[i] - pb[i] == 1, $sformatf("t5_pops_i%0d", i), pops[i] - pb[i], 1);
      check(busy_a[i] == 1'b0, $sformatf("t5_busy_i%0d", i), busy_a[i], 0);
      check(wr_p[i] - rd_p[i] == 2, $sformatf("t5_queued_i%0d", i), wr_p[i] - rd_p[i], 2);
    end
    for (int i = 0; i < 2; i++) begin lb[i] = log_n[i]; pb[i] = pops[i]; end
    enable = 1'b1;
    n = 0;
    while (n < 40 && log_n[0] - lb[0] < 1) begin step(); n++; end
    check(n < 40, "t5_wait_one_byte", n, 40);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check(valid_a[i] == 1'b0, $sformatf("t5_rst_valid_i%0d", i), valid_a[i], 0);
      check(wcnt_a[i] == 16'h0000, $sformatf("t5_rst_count_i%0d", i), wcnt_a[i], 0);
    end
    step();
    step();
    rst_n = 1'b1;
    wait_quiet(40, "t5b");
    for (int i = 0; i < 2; i++) begin
      check(log_n[i] - lb[i] == 5, $sformatf("t5b_nbytes_i%0d", i), log_n[i] - lb[i], 5);
      eb = (i == 1) ? 8'h12 : 8'h78;
      check(log_b[i][lb[i]] == eb, $sformatf("t5b_first_i%0d", i), log_b[i][lb[i]], eb);
      check_bytes(i, lb[i] + 1, 32'h9ABCDEF0, "t5b_w2");
      check(pops[i] - pb[i] == 2, $sformatf("t5b_pops_i%0d", i), pops[i] - pb[i], 2);
      check(wcnt_a[i] == 16'd1, $sformatf("t5b_count_i%0d", i), wcnt_a[i], 1);
    end

    // randomized traffic, enable gating and back-pressure
    for (int c = 0; c < 400; c++) begin
      push_en    = ($urandom_range(0, 2) == 0);
      push_data  = $urandom;
      enable     = ($urandom_range(0, 7) != 0);
      byte_ready = 1'($urandom_range(0, 1));
      step();
    end
    push_en    = 1'b0;
    enable     = 1'b1;
    byte_ready = 1'b1;
    wait_quiet(600, "t6");
    for (int i = 0; i < 2; i++) begin
      check(wr_p[i] == rd_p[i], $sformatf("t6_fifo_drained_i%0d", i), wr_p[i] - rd_p[i], 0);
      check(exp_rd[i] == exp_wr[i], $sformatf("t6_bytes_drained_i%0d", i), exp_wr[i] - exp_rd[i], 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
